tmr_fault_manager: RTL and testbench
====================================

# tmr_fault_manager

Sequencing controller for the 3-way majority voter of the fault-tolerant cv32e40p replicas. It watches the voter's per-replica error flags, keeps a leaky error count per replica and, when one replica crosses a threshold, drops the voter to two-input mode. It then selects the surviving pair, requests resynchronisation of the faulty replica, and restores full TMR after a clean probation period. It sits beside each voter instance and drives that voter's `only_two_i` and the input-pair steering muxes.

## Interface
Parameters:
- `CNT_W`, 4: width of each per-replica error counter.
- `THRESHOLD`, 4: counter value at which a replica is declared faulty (1..2^CNT_W-1).
- `WINDOW`, 256: leak period in cycles; power of two, ≥2.
- `PROBATION`, 16: clean valid votes required in RESYNC before returning to TMR.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `vote_valid_i` in 1: the voter outputs this cycle are meaningful.
- `err_detected_i` in 3: voter `err_detected_1/2/3`, bit k = replica/voter-input k+1.
- `only_two_o` out 1: drives voter `only_two_i`.
- `sel_a_o` out 2: replica id steered to voter input 1.
- `sel_b_o` out 2: replica id steered to voter input 2.
- `faulty_o` out 3: one-hot faulty-replica flag.
- `resync_req_o` out 1: resynchronisation request.
- `resync_id_o` out 2: replica being resynchronised.
- `resync_ack_i` in 1: resynchronisation done.
- `fatal_o` out 1: uncorrectable condition. Sticky until reset.
- `state_o` out 2: current state, for debug.

## Operation
- States: TMR=0, DMR=1, RESYNC=2, FATAL=3.
- TMR:
  - On `vote_valid_i`, counter k increments (saturating) when its flag is set.
  - All three flags set means all outputs differ: go to FATAL.
  - Exactly one counter reaching `THRESHOLD` (replica f): go to DMR. Set `faulty_o[f]`, `only_two_o`=1 and `resync_req_o`=1 with `resync_id_o`=f.
  - Steering pair by faulty replica: f=0 → (1,2); f=1 → (0,2); f=2 → (0,1).
  - Two or more counters reaching `THRESHOLD` in the same cycle: go to FATAL.
- Leak: a free-running window counter wraps every `WINDOW` cycles. At each wrap in TMR, all counters decrement by 1, saturating at 0. A counter that both increments and leaks in the same cycle is unchanged.
- DMR:
  - `resync_req_o` is held until `resync_ack_i` is sampled high. It deasserts the next cycle, and the state moves to RESYNC with the probation counter cleared.
  - A valid vote with `err_detected_i[0]` or `err_detected_i[1]` set (the pair disagrees): go to FATAL.
- RESYNC:
  - The steering pair and `only_two_o` are unchanged.
  - Each clean valid vote increments the probation counter; a disagreeing vote goes to FATAL.
  - At `PROBATION` clean votes: go to TMR. Clear counter f and `faulty_o`, set `only_two_o`=0, and restore `sel_a_o`/`sel_b_o` to 0/1.
- `resync_ack_i` outside DMR is ignored.
- FATAL: `fatal_o`=1. All other outputs are frozen at their last values. Exit only by reset.
- Reset mid-operation: any state returns to TMR next cycle and any outstanding request is dropped.

## Timing
- All outputs are registered.
- Reset values: `only_two_o`=0, `sel_a_o`=0, `sel_b_o`=1, `faulty_o`=000, `resync_req_o`=0, `resync_id_o`=0, `fatal_o`=0, `state_o`=TMR. All counters are 0.
- A flag sampled at edge N updates its counter at edge N.
- The threshold-crossing vote is sampled at edge N. State, `only_two_o`, steering and `resync_req_o` change at edge N, so they are visible in cycle N+1.
- Handshake latency:
  - Ack sampled at edge M: `resync_req_o` is low and `state_o`=RESYNC from cycle M+1.
  - `resync_ack_i` may be held high for more than one cycle; only the first sample counts.
- Return to TMR is visible the cycle after the `PROBATION`-th clean vote is sampled.
- FATAL is entered one cycle after the offending vote.
- `vote_valid_i`=0 cycles do not count or change state. Leak still runs during them.

## Structure
- Package `tmr_ctrl_pkg`:
  - `tmr_state_e` enum.
  - `replica_id_t` (2-bit).
  - Reset steering constants.
  - `pair_of(faulty)` function returning the surviving pair.
- Sub-module `tmr_err_counter`: saturating up/down counter with separate `inc` and `dec` inputs and a `clr` input. It is instantiated three times.

## Test plan
- Reset, then 100 clean valid votes: all outputs stay at reset values, `state_o`=0.
- Four valid votes flagging replica 2 (`err_detected_i`=100) within one window: cycle after the 4th vote shows `only_two_o`=1, sel=(0,1), `faulty_o`=100, `resync_req_o`=1, `resync_id_o`=2.
- From DMR: ack after 5 cycles, then 16 clean votes. Required: req drops the cycle after ack, then `state_o`=TMR, `only_two_o`=0, sel=(0,1), `faulty_o`=000.
- With `WINDOW`=8: 3 flags on replica 0, then 24 idle cycles. Counter reaches 0; 3 further flags do not trigger DMR.
- All three flags in TMR, or `err_detected_i`=011 in DMR: `fatal_o`=1 next cycle and stays high. `rst_i` for 1 cycle restores reset values.
- Replicas 0 and 1 both reach `THRESHOLD` on the same vote: FATAL, no resync request issued.

Source files
------------

// File: rtl/tmr_ctrl_pkg.sv
// Shared types and helpers for the TMR voter sequencing controller.
package tmr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_TMR    = 2'd0,
    ST_DMR    = 2'd1,
    ST_RESYNC = 2'd2,
    ST_FATAL  = 2'd3
  } tmr_state_e;

  typedef logic [1:0] replica_id_t;

  typedef struct packed {
    replica_id_t a;
    replica_id_t b;
  } replica_pair_t;

  localparam replica_id_t RST_SEL_A = 2'd0;
  localparam replica_id_t RST_SEL_B = 2'd1;

  // Surviving pair once one replica is excluded from the vote.
  function automatic replica_pair_t pair_of(input replica_id_t faulty);
    replica_pair_t p;
    case (faulty)
      2'd0:    begin p.a = 2'd1; p.b = 2'd2; end
      2'd1:    begin p.a = 2'd0; p.b = 2'd2; end
      default: begin p.a = 2'd0; p.b = 2'd1; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tmr_fault_manager_err_counter.sv
// Saturating up/down per-replica error counter; inc and dec together cancel.
module tmr_err_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt_next
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_next = r_cnt;
    if (i_clr) begin
      w_next = '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != '1) w_next = r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) w_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_next;
  end

  assign o_cnt_next = w_next;

endmodule

// File: rtl/tmr_fault_manager.sv
// Sequencing controller for a 3-way majority voter: leaky per-replica error
// counts, fallback to two-input mode, resync handshake and probation.
module tmr_fault_manager
  import tmr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned THRESHOLD = 4,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned PROBATION = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vote_valid_i,
  input  logic [2:0] err_detected_i,
  output logic       only_two_o,
  output logic [1:0] sel_a_o,
  output logic [1:0] sel_b_o,
  output logic [2:0] faulty_o,
  output logic       resync_req_o,
  output logic [1:0] resync_id_o,
  input  logic       resync_ack_i,
  output logic       fatal_o,
  output logic [1:0] state_o
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned PROB_W = $clog2(PROBATION + 1);

  tmr_state_e         r_state;
  logic [WIN_W-1:0]   r_win;
  logic [PROB_W-1:0]  r_prob;
  logic               r_only_two;
  replica_id_t        r_sel_a;
  replica_id_t        r_sel_b;
  logic [2:0]         r_faulty;
  logic               r_req;
  replica_id_t        r_id;
  logic               r_fatal;

  logic               w_in_tmr;
  logic               w_leak;
  logic               w_pair_err;
  logic               w_prob_done;
  logic               w_back_to_tmr;
  logic [2:0]         w_inc;
  logic [2:0]         w_clr;
  logic [2:0]         w_reach;
  logic [1:0]         w_nreach;
  replica_id_t        w_reach_id;
  replica_pair_t      w_pair;
  logic [CNT_W-1:0]   w_cnt_next [3];

  assign w_in_tmr      = (r_state == ST_TMR);
  assign w_leak        = &r_win;
  assign w_pair_err    = err_detected_i[0] | err_detected_i[1];
  assign w_prob_done   = (r_prob == PROB_W'(PROBATION - 1));
  assign w_back_to_tmr = (r_state == ST_RESYNC) && vote_valid_i && !w_pair_err && w_prob_done;

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    assign w_inc[k] = w_in_tmr && vote_valid_i && err_detected_i[k];
    assign w_clr[k] = w_back_to_tmr && (r_id == replica_id_t'(k));

    tmr_err_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_inc      (w_inc[k]),
      .i_dec      (w_in_tmr && w_leak),
      .i_clr      (w_clr[k]),
      .o_cnt_next (w_cnt_next[k])
    );

    // Only a counter that is incrementing this cycle can newly cross.
    assign w_reach[k] = w_inc[k] && (w_cnt_next[k] >= CNT_W'(THRESHOLD));
  end

  assign w_nreach   = {1'b0, w_reach[0]} + {1'b0, w_reach[1]} + {1'b0, w_reach[2]};
  assign w_reach_id = w_reach[0] ? 2'd0 : (w_reach[1] ? 2'd1 : 2'd2);
  assign w_pair     = pair_of(w_reach_id);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_TMR;
      r_win      <= '0;
      r_prob     <= '0;
      r_only_two <= 1'b0;
      r_sel_a    <= RST_SEL_A;
      r_sel_b    <= RST_SEL_B;
      r_faulty   <= '0;
      r_req      <= 1'b0;
      r_id       <= '0;
      r_fatal    <= 1'b0;
    end else begin
      r_win <= r_win + 1'b1;
      case (r_state)
        ST_TMR: begin
          if (vote_valid_i) begin
            if ((&err_detected_i) || (w_nreach >= 2'd2)) begin
              r_state <= ST_FATAL;
              r_fatal <= 1'b1;
            end else if (w_nreach == 2'd1) begin
              r_state    <= ST_DMR;
              r_only_two <= 1'b1;
              r_faulty   <= w_reach;
              r_req      <= 1'b1;
              r_id       <= w_reach_id;
              r_sel_a    <= w_pair.a;
              r_sel_b    <= w_pair.b;
            end
          end
        end
        ST_DMR: begin
          if (vote_valid_i && w_pair_err) begin
            r_state <= ST_FATAL;
            r_fatal <= 1'b1;
          end else if (resync_ack_i) begin
            r_state <= ST_RESYNC;
            r_req   <= 1'b0;
            r_prob  <= '0;
          end
        end
        ST_RESYNC: begin
          if (vote_valid_i) begin
            if (w_pair_err) begin
              r_state <= ST_FATAL;
              r_fatal <= 1'b1;
            end else if (w_prob_done) begin
              r_state    <= ST_TMR;
              r_faulty   <= '0;
              r_only_two <= 1'b0;
              r_sel_a    <= RST_SEL_A;
              r_sel_b    <= RST_SEL_B;
            end else begin
              r_prob <= r_prob + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign only_two_o   = r_only_two;
  assign sel_a_o      = r_sel_a;
  assign sel_b_o      = r_sel_b;
  assign faulty_o     = r_faulty;
  assign resync_req_o = r_req;
  assign resync_id_o  = r_id;
  assign fatal_o      = r_fatal;
  assign state_o      = r_state;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed-vector bench for tmr_fault_manager with a queue-based scoreboard.
module tb_tmr_fault_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       vv;
  logic [2:0] err;
  logic       ack;
  logic       only_two;
  logic [1:0] sel_a, sel_b;
  logic [2:0] faulty;
  logic       req;
  logic [1:0] rid;
  logic       fatal;
  logic [1:0] st;

  always #5 clk = ~clk;

  tmr_fault_manager #(
    .CNT_W(4), .THRESHOLD(4), .WINDOW(8), .PROBATION(16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .vote_valid_i   (vv),
    .err_detected_i (err),
    .only_two_o     (only_two),
    .sel_a_o        (sel_a),
    .sel_b_o        (sel_b),
    .faulty_o       (faulty),
    .resync_req_o   (req),
    .resync_id_o    (rid),
    .resync_ack_i   (ack),
    .fatal_o        (fatal),
    .state_o        (st)
  );

  typedef struct packed {
    logic       o2;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] f;
    logic       rq;
    logic [1:0] id;
    logic       fa;
    logic [1:0] st;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  assign act = {only_two, sel_a, sel_b, faulty, req, rid, fatal, st};

  function automatic obs_t mk(input logic o2, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] f, input logic rq, input logic [1:0] id,
                              input logic fa, input logic [1:0] s);
    return {o2, sa, sb, f, rq, id, fa, s};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got only2=%b sel=%0d/%0d faulty=%b req=%b id=%0d fatal=%b st=%0d; expected only2=%b sel=%0d/%0d faulty=%b req=%b id=%0d fatal=%b st=%0d",
                 n, act.o2, act.sa, act.sb, act.f, act.rq, act.id, act.fa, act.st,
                 e.o2, e.sa, e.sb, e.f, e.rq, e.id, e.fa, e.st);
      end
    end
  end

  task automatic chk(input string n, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step(input logic v, input logic [2:0] e, input logic a);
    vv = v; err = e; ack = a;
    @(posedge clk); #1;
    vv = 1'b0; err = 3'b000; ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vv = 1'b0; err = 3'b000; ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  obs_t RST;

  initial begin
    RST = mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);
    rst = 1'b1; vv = 1'b0; err = 3'b000; ack = 1'b0;

    do_reset();
    chk("reset_values", RST);
    for (int i = 0; i < 100; i++) step(1'b1, 3'b000, 1'b0);
    chk("clean_100_votes", RST);

    // Replica 2 crosses the threshold on the 4th flagged vote.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 1'b0);
    chk("below_threshold", RST);
    step(1'b1, 3'b100, 1'b0);
    chk("dmr_entry_f2", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b1, 2'd2, 1'b0, 2'd1));
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 1'b0);
    chk("dmr_req_held", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b1, 2'd2, 1'b0, 2'd1));
    step(1'b0, 3'b000, 1'b1);
    chk("ack_to_resync", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b0, 2'd2, 1'b0, 2'd2));
    step(1'b0, 3'b000, 1'b1);
    chk("ack_held_ignored", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b0, 2'd2, 1'b0, 2'd2));
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 3'b100, 1'b0);
      step(1'b0, 3'b000, 1'b0);
    end
    chk("probation_15", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b0, 2'd2, 1'b0, 2'd2));
    step(1'b1, 3'b000, 1'b0);
    chk("back_to_tmr", mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd2, 1'b0, 2'd0));
    step(1'b1, 3'b100, 1'b0);
    chk("counter_f_cleared", mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd2, 1'b0, 2'd0));

    // Steering for the other two faulty replicas.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 1'b0);
    chk("dmr_entry_f0", mk(1'b1, 2'd1, 2'd2, 3'b001, 1'b1, 2'd0, 1'b0, 2'd1));
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b010, 1'b0);
    chk("dmr_entry_f1", mk(1'b1, 2'd0, 2'd2, 3'b010, 1'b1, 2'd1, 1'b0, 2'd1));

    // Leak: WINDOW=8, three wraps in 24 idle cycles drain a count of 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b0);
    chk("leak_pre", RST);
    for (int i = 0; i < 24; i++) step(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b001, 1'b0);
    chk("leak_drained", RST);

    do_reset();
    step(1'b1, 3'b111, 1'b0);
    chk("all_three_fatal", mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd0, 1'b1, 2'd3));
    step(1'b1, 3'b001, 1'b1);
    step(1'b0, 3'b000, 1'b0);
    chk("fatal_sticky", mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd0, 1'b1, 2'd3));
    do_reset();
    chk("reset_after_fatal", RST);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b011, 1'b0);
    chk("dmr_disagree_fatal", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b1, 2'd2, 1'b1, 2'd3));
    step(1'b0, 3'b000, 1'b1);
    chk("fatal_frozen_ack", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b1, 2'd2, 1'b1, 2'd3));
    do_reset();
    chk("reset_drops_req", RST);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b100, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b010, 1'b0);
    chk("resync_disagree_fatal", mk(1'b1, 2'd0, 2'd1, 3'b100, 1'b0, 2'd2, 1'b1, 2'd3));

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'b011, 1'b0);
    chk("double_threshold_fatal", mk(1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 2'd0, 1'b1, 2'd3));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
